lod_scan_sequencer: RTL and testbench
=====================================

Name: lod_scan_sequencer

Overview:
- Iterative zero-position scheduler around the LeadOneDet datapath.
- Accepts one operand word per valid/ready transaction, then emits one beat per '0' bit of that word, MSB first.
- Each beat carries the bit index and the one-hot position. The sequencer sets the reported bit in its working copy and re-runs detection on the next cycle.
- Typical use: free-slot / free-entry enumeration from an occupancy mask, and feeding normalisation-shift or allocation logic.

Parameters:
- width, 8, operand word width (>= 2).
- speed, lau_pkg::FAST, performance parameter forwarded unchanged to the internal LeadOneDet instance.
- IDXW (localparam), $clog2(width), index width.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous abort of the current word.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  operand accepted when in_valid_i & in_ready_o.
- in_data_i  in  width  operand word (bit set = occupied).
- out_valid_o  out  1  beat valid.
- out_ready_i  in  1  beat consumed when out_valid_o & out_ready_i.
- out_idx_o  out  IDXW  bit index of the reported zero.
- out_onehot_o  out  width  one-hot position of the reported zero (LeadOneDet output).
- out_last_o  out  1  final beat for the current word.
- out_empty_o  out  1  word had no zeros; single beat, onehot = 0, idx = 0.
- count_o  out  IDXW+1  beats handshaked so far for the current word.
- busy_o  out  1  state != IDLE.

Behaviour:
- Registers:
  - state {IDLE, SCAN}.
  - work[width-1:0].
  - count[IDXW:0].
- Reset (rst_i = 1 at a clock edge) forces: state = IDLE, work = 0, count = 0.
  - Resulting outputs: in_ready_o = 1, out_valid_o = 0, busy_o = 0, count_o = 0.
  - out_* data outputs are driven to 0 in IDLE.
  - Reset overrides flush_i and every handshake in the same cycle.
- Combinational detect path:
  - Z = LeadOneDet(work).
  - out_onehot_o = Z.
  - out_idx_o = binary encode of Z (0 when Z = 0).
  - all_ones = &work.
  - out_empty_o = SCAN & all_ones.
  - out_last_o = SCAN & (all_ones | &(work | Z)).
- IDLE:
  - in_ready_o = ~flush_i, out_valid_o = 0.
  - On accept: work <= in_data_i, count <= 0, state <= SCAN.
- SCAN:
  - out_valid_o = 1.
  - On beat handshake: work <= work | Z, count <= count + 1.
  - If out_last_o and no new accept in the same cycle: state <= IDLE.
- Overlap: in_ready_o = ~flush_i & (IDLE | (SCAN & out_ready_i & out_last_o)).
  - A word accepted on the last-beat handshake cycle loads work/count and stays in SCAN.
  - Its first beat is valid the next cycle, so no bubble between words.
- Latency: accept at cycle t gives the first beat valid at t+1. Beats are back-to-back while out_ready_i = 1.
  - A word with k zeros takes max(k,1) beats.
- Backpressure: while out_valid_o & ~out_ready_i, all out_* outputs and count_o hold stable. A beat is never dropped or repeated.
- flush_i in SCAN: state <= IDLE, count <= 0, and any beat handshake that cycle is ignored. in_ready_o = 0 while flush_i = 1. flush_i in IDLE has no effect.
- count_o saturates by construction at width (word 0).
- Beat ordering: zeros are reported strictly MSB to LSB, indices strictly decreasing.
- Behaviour is identical for speed = SLOW/MEDIUM/FAST. Only combinational depth differs.

Test Plan:
- width=8, load 8'b1110_1010, out_ready_i=1 → beats at t+1..t+3: idx 4/2/0, onehot 0x10/0x04/0x01, last only on idx 0, count_o 0,1,2 then IDLE with count 3.
- Load 0xFF → single beat: empty=1, last=1, onehot=0x00, idx=0; busy_o low the cycle after the handshake.
- Load 0x00 → 8 beats with idx 7..0, last on idx 0. Repeat with out_ready_i low for 3 cycles on the idx-5 beat: idx/onehot/count held stable, no beat lost.
- Back-to-back: present 0xEA then 0x7F continuously → 0x7F is accepted on the idx-0 last-beat cycle and its beat (idx 7, last, onehot 0x80) follows the next cycle with no gap.
- flush_i during the second beat of 0x00 → out_valid_o=0 next cycle, count_o=0, in_ready_o=1. Repeat with rst_i in place of flush_i mid-scan → same state, then a new load of 0xFE gives one beat with idx 0.
- Random 1000-word regression for each speed value against a reference model of zero positions. Also check in_ready_o = 0 whenever flush_i = 1.

Source files
------------

// File: rtl/lod_scan_sequencer.sv
// Zero-position scan sequencer: walks an operand word MSB first
// and emits one beat per clear bit, using a leading-zero detector.

package lau_pkg;
  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    MEDIUM = 2'd1,
    FAST   = 2'd2
  } speed_e;
endpackage

// Reports the most significant clear bit of i_vec as a one-hot vector.
// All-ones input yields zero. speed only trades logic depth.
module LeadOneDet #(
  parameter int              width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic [width-1:0] i_vec,
  output logic [width-1:0] o_onehot
);

  logic [width-1:0] w_free;

  assign w_free = ~i_vec;

  if (speed == lau_pkg::SLOW) begin : g_ripple

    logic w_seen;

    // linear priority chain from the MSB down
    always_comb begin
      w_seen   = 1'b0;
      o_onehot = '0;
      for (int i = width - 1; i >= 0; i--) begin
        o_onehot[i] = w_free[i] & ~w_seen;
        w_seen      = w_seen | w_free[i];
      end
    end

  end else begin : g_prefix

    localparam int STG = $clog2(width);

    logic [width-1:0] w_pre [STG+1];
    logic [width-1:0] w_incl;

    assign w_pre[0] = w_free;

    // log-depth suffix OR: w_incl[i] = |w_free[width-1:i]
    for (genvar s = 0; s < STG; s++) begin : g_stg
      for (genvar i = 0; i < width; i++) begin : g_bit
        if (i + (1 << s) < width) begin : g_or
          assign w_pre[s+1][i] =
            w_pre[s][i] | w_pre[s][i+(1<<s)];
        end else begin : g_pass
          assign w_pre[s+1][i] = w_pre[s][i];
        end
      end
    end

    assign w_incl   = w_pre[STG];
    assign o_onehot = w_incl & ~(w_incl >> 1);

  end

endmodule

module lod_scan_sequencer #(
  parameter int              width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST,
  localparam int             IDXW  = $clog2(width)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDXW-1:0]  out_idx_o,
  output logic [width-1:0] out_onehot_o,
  output logic             out_last_o,
  output logic             out_empty_o,
  output logic [IDXW:0]    count_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           r_state;
  logic [width-1:0] r_work;
  logic [IDXW:0]    r_count;

  logic [width-1:0] w_z;
  logic [IDXW-1:0]  w_idx;
  logic             w_scan;
  logic             w_all_ones;
  logic             w_last;
  logic             w_acc;
  logic             w_beat;

  LeadOneDet #(
    .width (width),
    .speed (speed)
  ) u_lod (
    .i_vec    (r_work),
    .o_onehot (w_z)
  );

  // binary encode of the one-hot detector output
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < width; i++) begin
      if (w_z[i]) begin
        w_idx = w_idx | IDXW'(i);
      end
    end
  end

  assign w_scan     = (r_state == SCAN);
  assign w_all_ones = &r_work;
  assign w_last     = w_scan
                    & (w_all_ones | (&(r_work | w_z)));

  // a new word may load on the last-beat handshake: no bubble
  assign in_ready_o = ~flush_i
                    & (~w_scan | (out_ready_i & w_last));

  assign w_acc  = in_valid_i & in_ready_o;
  assign w_beat = w_scan & out_ready_i;

  assign out_valid_o  = w_scan;
  assign out_onehot_o = w_scan ? w_z : '0;
  assign out_idx_o    = w_scan ? w_idx : '0;
  assign out_last_o   = w_last;
  assign out_empty_o  = w_scan & w_all_ones;
  assign count_o      = r_count;
  assign busy_o       = w_scan;

  // load, mark-reported-bit and flush sequencing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_count <= '0;
    end else if (w_scan && flush_i) begin
      r_state <= IDLE;
      r_count <= '0;
    end else if (w_acc) begin
      r_work  <= in_data_i;
      r_count <= '0;
      r_state <= SCAN;
    end else if (w_beat) begin
      r_work  <= r_work | w_z;
      r_count <= r_count + {{IDXW{1'b0}}, 1'b1};
      if (w_last) begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_lod_scan_sequencer.sv
// Bench for lod_scan_sequencer: directed table, corner sequences
// and a random scoreboard run across all three speed settings.

module tb_lod_scan_sequencer;
  import lau_pkg::*;

  localparam int W  = 8;
  localparam int IW = 3;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic in_valid;
  logic out_ready;
  logic [W-1:0] in_data;

  logic          in_ready [ND];
  logic          ov       [ND];
  logic          olast    [ND];
  logic          oempty   [ND];
  logic          obusy    [ND];
  logic [IW-1:0] oidx     [ND];
  logic [W-1:0]  ooh      [ND];
  logic [IW:0]   ocnt     [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    lod_scan_sequencer #(
      .width (W),
      .speed (speed_e'(g))
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready[g]),
      .in_data_i    (in_data),
      .out_valid_o  (ov[g]),
      .out_ready_i  (out_ready),
      .out_idx_o    (oidx[g]),
      .out_onehot_o (ooh[g]),
      .out_last_o   (olast[g]),
      .out_empty_o  (oempty[g]),
      .count_o      (ocnt[g]),
      .busy_o       (obusy[g])
    );
  end

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
    logic [W-1:0]  oh;
    logic          last;
    logic          empty;
    logic [IW:0]   cnt;
  } beat_t;

  typedef struct {
    logic [W-1:0] data;
    int           beats;
    int           fidx;
    logic [W-1:0] foh;
    logic         fempty;
  } vec_t;

  beat_t q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  // reference: clear bits MSB first, or one empty beat
  function automatic void push_word(input logic [W-1:0] d);
    beat_t b;
    int n;
    int k;
    n = 0;
    for (int i = 0; i < W; i++) if (!d[i]) n++;
    if (n == 0) begin
      b = '{vld: 1'b1, idx: '0, oh: '0,
            last: 1'b1, empty: 1'b1, cnt: '0};
      q.push_back(b);
    end else begin
      k = 0;
      for (int i = W - 1; i >= 0; i--) begin
        if (!d[i]) begin
          b.vld   = 1'b1;
          b.idx   = IW'(i);
          b.oh    = W'(1) << i;
          b.last  = (k == n - 1);
          b.empty = 1'b0;
          b.cnt   = (IW+1)'(k);
          q.push_back(b);
          k++;
        end
      end
    end
  endfunction

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    beat_t a;
    for (int d = 0; d < ND; d++) begin
      if (flush) chk($sformatf("rdy_flush%0d", d),
                     32'(in_ready[d]), 32'd0);
    end
    if (rst) begin
      q.delete();
    end else if (flush && obusy[0]) begin
      q.delete();
    end else begin
      if (ov[0]) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL beat_extra act=idx%0d exp=none",
                   oidx[0]);
        end else begin
          for (int d = 0; d < ND; d++) begin
            a = '{vld: ov[d], idx: oidx[d], oh: ooh[d],
                  last: olast[d], empty: oempty[d],
                  cnt: ocnt[d]};
            chk($sformatf("beat_dut%0d", d),
                32'(a), 32'(q[0]));
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready[0]) begin
        push_word(in_data);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 60; c++) begin
      if (!obusy[0]) break;
      tick();
    end
    chk(nm, 32'(obusy[0]), 32'd0);
  endtask

  task automatic load(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  vec_t tbl[8];
  int nb;
  int acc0;
  int cyc;

  initial begin
    tbl[0] = '{8'hEA, 3, 4, 8'h10, 1'b0};
    tbl[1] = '{8'hFF, 1, 0, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 8, 7, 8'h80, 1'b0};
    tbl[3] = '{8'hFE, 1, 0, 8'h01, 1'b0};
    tbl[4] = '{8'h7F, 1, 7, 8'h80, 1'b0};
    tbl[5] = '{8'h55, 4, 7, 8'h80, 1'b0};
    tbl[6] = '{8'hAA, 4, 6, 8'h40, 1'b0};
    tbl[7] = '{8'hF0, 4, 3, 8'h08, 1'b0};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready[0]), 32'd1);
    chk("rst_valid", 32'(ov[0]), 32'd0);
    chk("rst_busy",  32'(obusy[0]), 32'd0);
    chk("rst_count", 32'(ocnt[0]), 32'd0);
    chk("rst_onehot", 32'(ooh[0]), 32'd0);
    chk("rst_idx",   32'(oidx[0]), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      wait_idle($sformatf("tbl%0d_pre_idle", v));
      load(tbl[v].data);
      chk($sformatf("tbl%0d_fidx", v),
          32'(oidx[0]), 32'(tbl[v].fidx));
      chk($sformatf("tbl%0d_foh", v),
          32'(ooh[0]), 32'(tbl[v].foh));
      chk($sformatf("tbl%0d_fempty", v),
          32'(oempty[0]), 32'(tbl[v].fempty));
      chk($sformatf("tbl%0d_fcnt", v),
          32'(ocnt[0]), 32'd0);
      nb = 0;
      for (int c = 0; c < 20 && obusy[0]; c++) begin
        if (ov[0] && out_ready) nb++;
        tick();
      end
      chk($sformatf("tbl%0d_beats", v), 32'(nb),
          32'(tbl[v].beats));
      chk($sformatf("tbl%0d_endcnt", v),
          32'(ocnt[0]), 32'(tbl[v].beats));
      chk($sformatf("tbl%0d_idle", v),
          32'(obusy[0]), 32'd0);
    end

    // all-ones word: busy drops right after the single beat
    load(8'hFF);
    chk("ff_last", 32'(olast[0]), 32'd1);
    tick();
    chk("ff_busy_after", 32'(obusy[0]), 32'd0);

    // backpressure held on the idx-5 beat of 0x00
    load(8'h00);
    for (int c = 0; c < 10; c++) begin
      if (oidx[0] == 3'd5) break;
      tick();
    end
    chk("bp_reach5", 32'(oidx[0]), 32'd5);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid", 32'(ov[0]), 32'd1);
      chk("bp_idx", 32'(oidx[0]), 32'd5);
      chk("bp_oh", 32'(ooh[0]), 32'h20);
      chk("bp_cnt", 32'(ocnt[0]), 32'd2);
    end
    out_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_endcnt", 32'(ocnt[0]), 32'd8);

    // back-to-back: 0x7F loads on the last beat of 0xEA
    in_valid = 1'b1;
    in_data  = 8'hEA;
    tick();
    in_data = 8'h7F;
    for (int c = 0; c < 10; c++) begin
      if (in_ready[0]) break;
      tick();
    end
    chk("b2b_ready", 32'(in_ready[0]), 32'd1);
    chk("b2b_idx0", 32'(oidx[0]), 32'd0);
    chk("b2b_last0", 32'(olast[0]), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", 32'(ov[0]), 32'd1);
    chk("b2b_idx7", 32'(oidx[0]), 32'd7);
    chk("b2b_oh", 32'(ooh[0]), 32'h80);
    chk("b2b_last", 32'(olast[0]), 32'd1);
    chk("b2b_cnt", 32'(ocnt[0]), 32'd0);
    tick();
    chk("b2b_idle", 32'(obusy[0]), 32'd0);

    // flush on the second beat of 0x00
    load(8'h00);
    tick();
    chk("fl_idx6", 32'(oidx[0]), 32'd6);
    flush = 1'b1;
    #1;
    chk("fl_ready0", 32'(in_ready[0]), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_valid", 32'(ov[0]), 32'd0);
    chk("fl_cnt", 32'(ocnt[0]), 32'd0);
    chk("fl_ready", 32'(in_ready[0]), 32'd1);

    // reset mid-scan, then a fresh 0xFE word
    load(8'h00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_valid", 32'(ov[0]), 32'd0);
    chk("rs_cnt", 32'(ocnt[0]), 32'd0);
    chk("rs_ready", 32'(in_ready[0]), 32'd1);
    load(8'hFE);
    chk("fe_idx", 32'(oidx[0]), 32'd0);
    chk("fe_oh", 32'(ooh[0]), 32'h01);
    chk("fe_last", 32'(olast[0]), 32'd1);
    tick();
    chk("fe_idle", 32'(obusy[0]), 32'd0);

    // random regression with backpressure and flushes
    acc0 = n_acc;
    cyc  = 0;
    while (n_acc < acc0 + 1000 && cyc < 30000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       in_data = 8'hFF;
        1:       in_data = 8'h00;
        default: in_data = W'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
      cyc++;
    end
    chk("rnd_words", 32'(n_acc - acc0 >= 1000), 32'd1);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    wait_idle("rnd_drain");
    tick();
    chk("rnd_queue", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
